// File: rtl/ext_ar_buffer_fifo.sv
// AXI AR-channel buffer: DEPTH-entry FIFO for read-address beats with optional
// fall-through and an outstanding-read limiter that waits for R-last beats.
module ext_ar_buffer_fifo #(
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned USER_WIDTH      = 6,
  parameter int unsigned DEPTH           = 4,
  parameter bit          FALL_THROUGH    = 1'b0,
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned AR_WIDTH  = 29 + ADDR_WIDTH + USER_WIDTH + ID_WIDTH,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1),
  localparam int unsigned OUT_WIDTH = (MAX_OUTSTANDING == 0) ? 1 : $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 slave_valid_i,
  input  logic [AR_WIDTH-1:0]  slave_ar_i,
  output logic                 slave_ready_o,
  output logic                 master_valid_o,
  output logic [AR_WIDTH-1:0]  master_ar_o,
  input  logic                 master_ready_i,
  input  logic                 r_last_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic [OUT_WIDTH-1:0] outstanding_o,
  output logic                 err_o
);

  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // With the limiter disabled the counter still tracks, saturating at all-ones.
  localparam logic [OUT_WIDTH-1:0] OUT_MAX =
      (MAX_OUTSTANDING == 0) ? {OUT_WIDTH{1'b1}} : OUT_WIDTH'(MAX_OUTSTANDING);

  logic [AR_WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [OUT_WIDTH-1:0] outstanding_q, outstanding_d;
  logic                 err_q, err_d;

  logic can_issue, empty, full, bypass;
  logic push, pop, bypass_hs, wr_en, rd_en;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode and output muxing; ready depends only on occupancy.
  always_comb begin
    can_issue = (MAX_OUTSTANDING == 0) || (outstanding_q < OUT_MAX);
    empty     = (count_q == '0);
    full      = (count_q == CNT_WIDTH'(DEPTH));
    bypass    = FALL_THROUGH && empty;

    slave_ready_o  = !full && !rst_i;
    master_valid_o = 1'b0;
    master_ar_o    = '0;
    if (!rst_i) begin
      if (bypass) begin
        master_valid_o = slave_valid_i && can_issue;
        master_ar_o    = slave_ar_i;
      end else begin
        master_valid_o = !empty && can_issue;
        master_ar_o    = mem_q[rptr_q];
      end
    end

    push      = slave_valid_i && slave_ready_o;
    pop       = master_valid_o && master_ready_i;
    // A bypassed beat never touches storage or pointers.
    bypass_hs = bypass && pop;
    wr_en     = push && !bypass_hs;
    rd_en     = pop && !bypass_hs;
  end

  // Next-state for pointers, occupancy, outstanding counter and error flag.
  always_comb begin
    wptr_d        = wr_en ? ptr_inc(wptr_q) : wptr_q;
    rptr_d        = rd_en ? ptr_inc(rptr_q) : rptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;

    if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      count_d = count_q - 1'b1;
    end

    if (pop && !r_last_i) begin
      if (outstanding_q != OUT_MAX) begin
        outstanding_d = outstanding_q + 1'b1;
      end
    end else if (r_last_i && !pop) begin
      if (outstanding_q == '0) begin
        err_d = 1'b1;
      end else begin
        outstanding_d = outstanding_q - 1'b1;
      end
    end
  end

  // State registers and storage; reset clears everything including entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      if (wr_en) begin
        mem_q[wptr_q] <= slave_ar_i;
      end
    end
  end

  assign count_o       = count_q;
  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ext_ar_buffer_fifo.sv
// Scoreboard bench: inst0 = DEPTH 4 / registered / limit 8,
// inst1 = DEPTH 3 / fall-through / limit 2.
module tb_ext_ar_buffer_fifo;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int USER_W = 6;
  localparam int AR_W   = 29 + ADDR_W + USER_W + ID_W;
  localparam int AOFF   = USER_W + ID_W;

  typedef logic [AR_W-1:0] beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  sv  [2];
  beat_t sar [2];
  logic  mr  [2];
  logic  rl  [2];

  logic       rdy0, mv0, err0;
  beat_t      mar0;
  logic [2:0] cnt0;
  logic [3:0] out0;
  logic       rdy1, mv1, err1;
  beat_t      mar1;
  logic [1:0] cnt1;
  logic [1:0] out1;

  // Reference model state: occupancy, outstanding reads, sticky error.
  int    m_cnt [2];
  int    m_out [2];
  bit    m_err [2];
  bit    accepted [2];
  beat_t sent0 [$];
  beat_t sent1 [$];
  int    checks   = 0;
  int    failures = 0;
  bit    mon_en   = 1'b0;

  always #5 clk = ~clk;

  ext_ar_buffer_fifo #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .USER_WIDTH(USER_W),
    .DEPTH(4), .FALL_THROUGH(1'b0), .MAX_OUTSTANDING(8)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .slave_valid_i(sv[0]), .slave_ar_i(sar[0]), .slave_ready_o(rdy0),
    .master_valid_o(mv0), .master_ar_o(mar0), .master_ready_i(mr[0]),
    .r_last_i(rl[0]), .count_o(cnt0), .outstanding_o(out0), .err_o(err0)
  );

  ext_ar_buffer_fifo #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .USER_WIDTH(USER_W),
    .DEPTH(3), .FALL_THROUGH(1'b1), .MAX_OUTSTANDING(2)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .slave_valid_i(sv[1]), .slave_ar_i(sar[1]), .slave_ready_o(rdy1),
    .master_valid_o(mv1), .master_ar_o(mar1), .master_ready_i(mr[1]),
    .r_last_i(rl[1]), .count_o(cnt1), .outstanding_o(out1), .err_o(err1)
  );

  function automatic int dep(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic int max_out(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  function automatic beat_t mk(input logic [31:0] addr, input logic [3:0] id);
    beat_t b;
    b              = '0;
    b[AOFF +: 32]  = addr;
    b[3:0]         = id;
    b[AR_W-1 -: 4] = 4'hA;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b[31:0]      = $urandom;
    b[63:32]     = $urandom;
    b[AR_W-1:64] = 7'($urandom);
    return b;
  endfunction

  task automatic check(input string nm, input int i, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %h expected %h", nm, i, act, exp);
    end
  endtask

  // Monitor: reset-state checks on reset, model comparison on every falling edge.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i]    = 0;
        m_out[i]    = 0;
        m_err[i]    = 1'b0;
        accepted[i] = 1'b0;
      end
      sent0.delete();
      sent1.delete();
      #1;
      check("rst_ready", 0, beat_t'(rdy0), '0);
      check("rst_valid", 0, beat_t'(mv0), '0);
      check("rst_ar", 0, mar0, '0);
      check("rst_count", 0, beat_t'(cnt0), '0);
      check("rst_outstanding", 0, beat_t'(out0), '0);
      check("rst_err", 0, beat_t'(err0), '0);
      check("rst_ready", 1, beat_t'(rdy1), '0);
      check("rst_valid", 1, beat_t'(mv1), '0);
      check("rst_ar", 1, mar1, '0);
      check("rst_count", 1, beat_t'(cnt1), '0);
      check("rst_outstanding", 1, beat_t'(out1), '0);
      check("rst_err", 1, beat_t'(err1), '0);
    end else if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        logic  d_rdy, d_mv, d_err;
        beat_t d_ar, head;
        int    d_cnt, d_out, qsize;
        bit    can, e_rdy, e_mv, push, pop, byp;
        if (i == 0) begin
          d_rdy = rdy0; d_mv = mv0; d_err = err0; d_ar = mar0;
          d_cnt = int'(cnt0); d_out = int'(out0); qsize = sent0.size();
          head  = (qsize > 0) ? sent0[0] : '0;
        end else begin
          d_rdy = rdy1; d_mv = mv1; d_err = err1; d_ar = mar1;
          d_cnt = int'(cnt1); d_out = int'(out1); qsize = sent1.size();
          head  = (qsize > 0) ? sent1[0] : '0;
        end
        can   = m_out[i] < max_out(i);
        e_rdy = m_cnt[i] != dep(i);
        // Only inst1 is fall-through; an empty FIFO then shows the slave beat.
        byp   = (i == 1) && (m_cnt[i] == 0);
        e_mv  = byp ? (sv[i] && can) : ((m_cnt[i] != 0) && can);
        check("slave_ready", i, beat_t'(d_rdy), beat_t'(e_rdy));
        check("master_valid", i, beat_t'(d_mv), beat_t'(e_mv));
        check("count", i, beat_t'(d_cnt), beat_t'(m_cnt[i]));
        check("outstanding", i, beat_t'(d_out), beat_t'(m_out[i]));
        check("err", i, beat_t'(d_err), beat_t'(m_err[i]));
        if (e_mv) begin
          check("beat_available", i, beat_t'(qsize > 0), beat_t'(1));
          if (qsize > 0) check("master_ar", i, d_ar, head);
        end
        push = sv[i] && e_rdy;
        pop  = e_mv && mr[i];
        accepted[i] = push;
        if (!(byp && pop)) m_cnt[i] = m_cnt[i] + int'(push) - int'(pop);
        if (pop && !rl[i]) begin
          if (m_out[i] < max_out(i)) m_out[i]++;
        end else if (rl[i] && !pop) begin
          if (m_out[i] == 0) m_err[i] = 1'b1;
          else m_out[i]--;
        end
        if (pop && qsize > 0) begin
          if (i == 0) void'(sent0.pop_front());
          else void'(sent1.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the model says it was taken.
  task automatic send(input int i, input beat_t b);
    sv[i]  = 1'b1;
    sar[i] = b;
    if (i == 0) sent0.push_back(b);
    else sent1.push_back(b);
    for (int n = 0; ; n++) begin
      tick();
      if (accepted[i]) break;
      if (n > 40) begin
        $display("FAIL send_timeout inst%0d: got no handshake, required one within 40 cycles", i);
        $fatal(1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; sar[i] = '0; mr[i] = 1'b0; rl[i] = 1'b0;
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Fill inst0 with the downstream stalled, then pop while full.
    for (int k = 0; k < 4; k++) send(0, mk(32'h100 * (k + 1), 4'(k)));
    sv[0] = 1'b0;
    tick(); tick();
    mr[0] = 1'b1;
    send(0, mk(32'h500, 4'd4));
    sv[0] = 1'b0;
    repeat (6) tick();
    mr[0] = 1'b0;

    // Fall-through bypass on an empty inst1.
    mr[1] = 1'b1;
    send(1, mk(32'hDEAD_0000, 4'd5));
    sv[1] = 1'b0;
    tick();
    rl[1] = 1'b1; tick(); rl[1] = 1'b0;

    // Limiter: third beat waits for an R-last.
    send(1, mk(32'h1000, 4'd1));
    send(1, mk(32'h2000, 4'd2));
    send(1, mk(32'h3000, 4'd3));
    sv[1] = 1'b0;
    repeat (3) tick();
    rl[1] = 1'b1; tick(); rl[1] = 1'b0;
    repeat (3) tick();

    // Drain inst0's five reads, then one extra R-last raises the sticky error.
    rl[0] = 1'b1; repeat (6) tick(); rl[0] = 1'b0;
    repeat (3) tick();

    // Build count=3 / outstanding=2 on inst1, then reset asynchronously.
    rl[1] = 1'b1; repeat (2) tick(); rl[1] = 1'b0;
    for (int k = 0; k < 5; k++) send(1, mk(32'h4000 + 32'(k), 4'(k)));
    sv[1] = 1'b0;
    for (int k = 0; k < 3; k++) send(0, mk(32'h8000 + 32'(k), 4'(k)));
    sv[0] = 1'b0;
    tick();
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Randomised traffic on both instances.
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (sv[i] && accepted[i]) sv[i] = 1'b0;
        if (!sv[i] && $urandom_range(0, 2) != 0) begin
          beat_t b;
          b      = rand_beat();
          sv[i]  = 1'b1;
          sar[i] = b;
          if (i == 0) sent0.push_back(b);
          else sent1.push_back(b);
        end
        mr[i] = $urandom_range(0, 9) < 7;
        rl[i] = $urandom_range(0, 19) < 3;
      end
      tick();
    end
    for (int cyc = 0; cyc < 30; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (sv[i] && accepted[i]) sv[i] = 1'b0;
        mr[i] = 1'b1;
        rl[i] = 1'($urandom_range(0, 1));
      end
      tick();
    end
    mon_en = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
